pattern_sequence_detector: RTL and testbench



---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_history_reg.sv | 26 ++
 rtl/pattern_sequence_detector.sv | 69 ++++++
 tb/tb_pattern_sequence_detector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Config storage is sized for the widest legal pattern (64 bits); unused upper bits stay zero.
package seq_det_pkg;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = 16;
  localparam int PAT_W       = 64;
  localparam int PLEN_W      = 7;

  typedef struct packed {
    logic [PAT_W-1:0]  pattern;
    logic [PLEN_W-1:0] len;
    logic              overlap;
  } seq_cfg_t;

  // Low 'len' bits set; len=64 yields all ones without shifting out of range.
  function automatic logic [PAT_W-1:0] len_mask(input logic [PLEN_W-1:0] len);
    if (len >= PLEN_W'(PAT_W)) return '1;
    return (PAT_W'(1) << len) - PAT_W'(1);
  endfunction
endpackage

// File: rtl/seq_history_reg.sv
// Serial history shift register with a saturating count of bits seen since the last flush.
// Flush always zeroes fill; hist shifts if a bit arrives, otherwise flush clears it.
module seq_history_reg #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               shift_en,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist,
  output logic [LEN_W-1:0]   fill
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift_en)   hist <= {hist[MAX_LEN-2:0], bit_in};
      else if (flush) hist <= '0;
      if (flush)                                        fill <= '0;
      else if (shift_en && fill != LEN_W'(MAX_LEN))     fill <= fill + LEN_W'(1);
    end
  end
endmodule

// File: rtl/pattern_sequence_detector.sv
// Runtime-programmable serial pattern detector with overlap control, a registered
// detect pulse and a saturating match counter.
module pattern_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int  MAX_LEN = DEF_MAX_LEN,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               seq,
  input  logic               valid,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);
  seq_cfg_t           cfg_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill, fill_n;
  logic [PAT_W-1:0]   cand;
  logic               accept, match, flush;

  assign accept = valid && !cfg_load;
  assign fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  // Post-shift history built from the registered history and the incoming bit.
  assign cand   = (PAT_W'(hist) << 1) | PAT_W'(seq);
  assign match  = accept && armed && (PLEN_W'(fill_n) >= cfg_q.len) &&
                  (((cand ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0);
  assign flush  = cfg_load || (match && !cfg_q.overlap);

  seq_history_reg #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .shift_en (accept),
    .bit_in   (seq),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q <= '0;
      armed <= 1'b0;
    end else if (cfg_load) begin
      cfg_q.pattern <= PAT_W'(cfg_pattern);
      cfg_q.len     <= PLEN_W'(cfg_len);
      cfg_q.overlap <= cfg_overlap;
      armed         <= (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      detected    <= 1'b0;
      match_count <= '0;
    end else begin
      detected <= match;
      if (cnt_clr)                        match_count <= '0;
      else if (match && match_count != '1) match_count <= match_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pattern_sequence_detector.sv
// Scoreboard bench: driver pushes expected outputs from a bit-queue reference model,
// monitor pops and compares each cycle; two DUTs share stimulus (CNT_W=16 and CNT_W=2).
module tb_pattern_sequence_detector;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0, resetn = 1'b0;
  logic          cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0, seq = 1'b0, valid = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          detected, armed, detected2, armed2;
  logic [15:0]   match_count;
  logic [1:0]    match_count2;

  always #5 clk = ~clk;

  pattern_sequence_detector #(.MAX_LEN(ML), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq(seq),
    .valid(valid), .detected(detected), .match_count(match_count), .armed(armed)
  );

  pattern_sequence_detector #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq(seq),
    .valid(valid), .detected(detected2), .match_count(match_count2), .armed(armed2)
  );

  typedef struct { bit det; int cnt; bit arm; int cnt2; } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;

  // Reference model: every accepted bit since the last cfg_load, plus bits since last flush.
  bit [ML-1:0] m_pat;
  int          m_len, m_fresh, m_raw;
  bit          m_ov, m_arm, m_det;
  bit          m_bits[$];

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_pat = '0; m_len = 0; m_ov = 0; m_arm = 0; m_det = 0;
    m_bits.delete(); m_fresh = 0; m_raw = 0;
  endtask

  task automatic model_edge();
    bit hit = 0;
    if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
      m_arm = (m_len >= 1) && (m_len <= ML);
      m_bits.delete(); m_fresh = 0; m_det = 0;
    end else if (valid) begin
      m_bits.push_back(seq);
      if (m_bits.size() > 64) void'(m_bits.pop_front());
      m_fresh++;
      hit = m_arm && (m_fresh >= m_len);
      if (hit)
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
      if (hit && !m_ov) m_fresh = 0;
      m_det = hit;
    end else begin
      m_det = 0;
    end
    if (cnt_clr) m_raw = 0;
    else if (hit) m_raw++;
    sbq.push_back('{m_det, (m_raw > 65535) ? 65535 : m_raw, m_arm, (m_raw > 3) ? 3 : m_raw});
  endtask

  task automatic step(input bit v, input bit s, input bit ld = 0, input bit clr = 0);
    valid = v; seq = s; cfg_load = ld; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic load(input bit [ML-1:0] pat, input int len, input bit ov, input bit v, input bit s);
    cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ov;
    step(v, s, 1'b1, 1'b0);
  endtask

  task automatic send_bits(input bit [63:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, b[i]);
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_det", detected, 0);
    chk("rst_cnt", match_count, 0);
    chk("rst_armed", armed, 0);
    chk("rst_cnt2", match_count2, 0);
    sbq.delete();
    model_reset();
    valid = 0; cfg_load = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("detected", detected, e.det);
        chk("match_count", match_count, e.cnt);
        chk("armed", armed, e.arm);
        chk("detected_c2", detected2, e.det);
        chk("match_count_c2", match_count2, e.cnt2);
        chk("armed_c2", armed2, e.arm);
      end
    end
  end

  initial begin
    do_reset();
    // no configuration yet: nothing may match
    send_bits(64'b10110, 5); step(0, 0);
    chk("nocfg_cnt", match_count, 0);
    chk("nocfg_armed", armed, 0);

    // overlapping
    load(ML'(5'b10110), 5, 1'b1, 1'b0, 1'b0);
    send_bits(64'b10110110, 8); step(0, 0);
    chk("ov_cnt", match_count, 2);

    // non-overlapping
    step(0, 0, 0, 1);
    load(ML'(5'b10110), 5, 1'b0, 1'b1, 1'b1);
    send_bits(64'b10110110, 8); step(0, 0);
    chk("nov_cnt", match_count, 1);

    // valid gaps between bits
    step(0, 0, 0, 1);
    load(ML'(4'b1011), 4, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, (i == 2) ? 1'b0 : 1'b1);
      repeat (3) step(1'b0, 1'($urandom_range(0, 1)));
    end
    chk("gap_cnt", match_count, 1);

    // full-length pattern
    step(0, 0, 0, 1);
    load(16'hA5C3, 16, 1'b0, 1'b0, 1'b0);
    send_bits(64'h5A5C3, 20); step(0, 0);
    chk("len16_cnt", match_count, 1);

    // illegal lengths
    load(ML'(5'b10110), 0, 1'b1, 1'b0, 1'b0);
    chk("len0_armed", armed, 0);
    send_bits(64'b10110, 5); step(0, 0);
    chk("len0_cnt", match_count, 1);
    load(16'hFFFF, 20, 1'b1, 1'b0, 1'b0);
    chk("len20_armed", armed, 0);
    send_bits(64'hFFFFFF, 24);

    // counter saturation and clear priority
    load(ML'(1'b1), 1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    repeat (5) step(1, 1);
    step(0, 0);
    chk("sat_cnt2", match_count2, 3);
    chk("sat_cnt16", match_count, 5);
    step(1, 1, 0, 1);
    chk("clr_prio_cnt", match_count, 0);
    chk("clr_prio_det", detected, 1);

    // cfg_load in the middle of a pattern flushes history and drops that sample
    load(ML'(5'b10110), 5, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    send_bits(64'b101, 3);
    load(ML'(5'b10110), 5, 1'b1, 1'b1, 1'b1);
    send_bits(64'b10, 2); step(0, 0);
    chk("midcfg_cnt", match_count, 0);

    // randomized traffic; cfg_* wiggles without the strobe must be ignored
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0)
        load(ML'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20))
                                                         : int'($urandom_range(1, 4)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else begin
        cfg_pattern = ML'($urandom); cfg_len = LW'($urandom_range(0, 20));
        cfg_overlap = 1'($urandom_range(0, 1));
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
             ($urandom_range(0, 99) == 0));
      end
    end

    // asynchronous reset while detected is high
    load(ML'(3'b101), 3, 1'b1, 1'b0, 1'b0);
    send_bits(64'b101, 3);
    chk("pre_rst_det", detected, 1);
    do_reset();
    step(1, 1);
    chk("post_rst_armed", armed, 0);
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
